// File: rtl/pipeline_hazard_controller_if.sv
// Handshake bundle between the hazard controller and the pipeline datapath.
// The master side drives hazard sources; the slave side is the controller.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_write_reg;
    logic             mem_busy;
    logic             wb_redirect;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg,
        output mem_busy, wb_redirect,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
        input  mem_wb_write, if_id_flush, id_ex_flush, ex_mem_flush,
        input  mem_wb_flush, state, stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_write_reg,
        input  mem_busy, wb_redirect,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
        output mem_wb_write, if_id_flush, id_ex_flush, ex_mem_flush,
        output mem_wb_flush, state, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, mem freeze, redirect.
// Statistics counters exist only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller #(
    parameter int REFILL_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input logic                          clk,
    input logic                          reset,
    pipeline_hazard_controller_if.slave  bus
);
    localparam int RW = (REFILL_CYCLES > 2) ? $clog2(REFILL_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2,
        REFILL   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] refill_q, refill_d;
    logic          hz_lu, hz_rd, rd_masked;

    // A freeze that interrupted a refill keeps the redirect mask alive.
    assign rd_masked = (state_q == REFILL) ||
                       (state_q == FREEZE && refill_q != '0);
    assign hz_rd = bus.wb_redirect && !rd_masked;
    assign hz_lu = bus.ex_mem_read && (bus.ex_write_reg != 5'd0) &&
                   ((bus.ex_write_reg == bus.id_rs) ||
                    (bus.id_uses_rt && bus.ex_write_reg == bus.id_rt));

    always_comb begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_write  = 1'b1;
        bus.ex_mem_write = 1'b1;
        bus.mem_wb_write = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.mem_wb_flush = 1'b0;
        state_d          = RUN;
        refill_d         = refill_q;

        unique case (state_q)
            FREEZE: begin
                if (refill_q != '0) state_d = REFILL;
            end
            REFILL: begin
                if (refill_q != '0) begin
                    state_d  = REFILL;
                    refill_d = refill_q - 1'b1;
                end
            end
            default: ;
        endcase

        if (reset) begin
            state_d  = RUN;
            refill_d = '0;
        end else if (bus.mem_busy) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_write  = 1'b0;
            bus.ex_mem_write = 1'b0;
            bus.mem_wb_write = 1'b0;
            state_d          = FREEZE;
            refill_d         = refill_q;
        end else if (hz_rd) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            bus.ex_mem_flush = 1'b1;
            bus.mem_wb_flush = 1'b1;
            state_d          = REFILL;
            refill_d         = RW'(REFILL_CYCLES - 1);
        end else if (hz_lu) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
            // An ongoing refill keeps counting down through the stall.
            if (state_d == RUN) state_d = LU_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            refill_q <= '0;
        end else begin
            state_q  <= state_d;
            refill_q <= refill_d;
        end
    end

    assign bus.state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             stall_inc, flush_inc;

    assign flush_inc = !bus.mem_busy && hz_rd;
    assign stall_inc = !bus.mem_busy && !hz_rd && hz_lu;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_inc && stall_count_q != '1)
            stall_count_d = stall_count_q + 1'b1;
        if (flush_inc && flush_count_q != '1)
            flush_count_d = flush_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;
`else
    assign bus.stall_count = '0;
    assign bus.flush_count = '0;
`endif
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX, and freezes the whole pipeline while the data memory reports busy.
- Flushes younger stages when WB redirects the PC on a taken branch or jump.
- Drives the write-enable and flush inputs of the PC register and the four pipeline registers; keeps saturating hazard statistics.

Parameters:
- REFILL_CYCLES, 4: number of un-frozen cycles after a redirect during which further redirect requests are masked. These cycles are WB bubbles.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq/bne, sw)
- ex_mem_read  in  1  MemRead control of the instruction in EX
- ex_write_reg  in  5  destination register of the instruction in EX
- mem_busy  in  1  data memory needs another cycle
- wb_redirect  in  1  WB is loading a non-sequential PC (branch taken or jump)
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- id_ex_write  out  1  ID/EX load enable
- ex_mem_write  out  1  EX/MEM load enable
- mem_wb_write  out  1  MEM/WB load enable
- if_id_flush  out  1  load a bubble into IF/ID
- id_ex_flush  out  1  load a bubble (all control zero) into ID/EX
- ex_mem_flush  out  1  load a bubble into EX/MEM
- mem_wb_flush  out  1  load a bubble into MEM/WB
- state  out  2  current FSM state: RUN=0, LU_STALL=1, FREEZE=2, REFILL=3
- stall_count  out  CNT_W  load-use stall cycles
- flush_count  out  CNT_W  accepted redirects

Behaviour:
- Control outputs are combinational from the registered state and the current inputs. The state and counters are registered on the clk rising edge.
- Reset (reset=1 at the edge):
  - state=RUN, refill counter=0, counters=0.
  - While reset is high, outputs are forced to: all *_write=1, all *_flush=0.
- Hazard terms:
  - hz_lu = ex_mem_read & (ex_write_reg!=0) & ((ex_write_reg==id_rs) | (id_uses_rt & ex_write_reg==id_rt)).
  - hz_rd = wb_redirect & (state!=REFILL).
- Priority, evaluated each cycle: mem_busy > hz_rd > hz_lu > none.
- Action for each priority case:
  - mem_busy: all *_write=0, all flushes=0. Next state FREEZE. The refill counter holds, and a masked redirect stays masked.
  - hz_rd: pc_write=1, all four flushes=1, all writes=1.
    - Next state REFILL, refill counter loaded with REFILL_CYCLES-1.
    - flush_count increments.
    - The redirecting instruction completes its WB write in this cycle.
  - hz_lu: pc_write=0, if_id_write=0, id_ex_flush=1; all other writes=1.
    - Next state LU_STALL; stall_count increments.
    - The stall lasts one cycle. Afterwards the load is in MEM and the forwarding unit supplies the value.
  - none: all writes=1, all flushes=0.
- Next-state when no higher-priority event fires:
  - From RUN, LU_STALL or FREEZE: go to RUN, except FREEZE returns to REFILL if the refill counter is nonzero.
  - REFILL: if the counter is 0 go to RUN, else decrement it and stay in REFILL.
- A load-use hazard in REFILL stalls normally. The refill counter still decrements in that cycle, and the state stays REFILL.
- wb_redirect during REFILL is ignored: no flush, no count.
- wb_redirect during mem_busy is not consumed. WB is frozen, so the same request is seen again once mem_busy drops.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-refill returns to RUN on the next edge. There is no pending state.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_count and flush_count are implemented as above.
- Undefined: no counter flops; both ports are tied to 0. Stall/flush behaviour is unchanged.

Test Plan:
- Load-use on rs: lw $8 in EX (ex_mem_read=1, ex_write_reg=8), ID reads id_rs=8.
  - Required: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle; state=1 next cycle; stall_count=1.
- Non-hazards:
  - ex_write_reg=0 with id_rs=0: no stall.
  - id_rt=8 with id_uses_rt=0: no stall.
  - ex_write_reg=8 with ex_mem_read=0: no stall.
- Redirect then masking: wb_redirect=1 for one cycle.
  - Required: all four flushes=1, flush_count=1, state=3 for 4 cycles.
  - wb_redirect=1 on the 2nd REFILL cycle: no flush, flush_count stays 1; state returns to 0.
- Freeze: mem_busy=1 for 3 cycles with hz_lu and wb_redirect also high.
  - Required: all writes=0, no flushes, state=2, counters unchanged.
  - When mem_busy drops: redirect is taken (flushes=1, flush_count+1); the stall is not taken.
- Saturation (CNT_W=4): 20 separate load-use hazards -> stall_count=15.
- Reset mid-REFILL: reset=1 for 1 cycle during REFILL -> state=0, counters=0, all writes=1; then wb_redirect is accepted immediately.
